cs_dequantization: RTL and testbench

Inverse of the compressive-sensing quantizer: rebuilds a measurement packet from quantized lane words received serially, one `DATA_WIDTH` lane per cycle, on a valid/ready stream. Each lane is left-shifted by the packet's shift amount. It then gets mid-point reconstruction and saturation. The block sits on the receive/reconstruction side of the link, ahead of the recovery datapath. It assembles `REG_BANK_DEPTH` lanes into one `PACKET_LEN` packet. A second packet can assemble while the first is held under output backpressure.

---
 rtl/cs_dequantization.sv | 101 ++++++++++
 tb/tb_cs_dequantization.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cs_dequantization.sv
// Compressive-sensing dequantizer: assembles serial quantized lanes into a packet,
// applying shift, mid-point reconstruction and saturation, with a two-packet skid.
module cs_dequantization #(
    parameter int DATA_WIDTH      = 16,
    parameter int REG_BANK_DEPTH  = 16,
    parameter int BIT_SHIFT_WIDTH = 4,
    parameter int PACKET_LEN      = DATA_WIDTH * REG_BANK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIT_SHIFT_WIDTH-1:0] bit_shift,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PACKET_LEN-1:0]      y_rec,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int CW = (REG_BANK_DEPTH > 1) ? $clog2(REG_BANK_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(REG_BANK_DEPTH - 1);
    localparam logic [BIT_SHIFT_WIDTH-1:0] SHIFT_ONE = BIT_SHIFT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] LANE_ONE = DATA_WIDTH'(1);

    logic [CW-1:0]                r_lane_cnt;
    logic                         r_asm_full;
    logic [BIT_SHIFT_WIDTH-1:0]   r_s_pkt;
    logic                         r_out_valid;
    logic [PACKET_LEN-1:0]        r_y_rec;
    logic [PACKET_LEN-1:0]        r_asm;

    logic                         w_accept;
    logic                         w_last;
    logic                         w_out_hs;
    logic                         w_out_free;
    logic [BIT_SHIFT_WIDTH-1:0]   w_shift;
    logic [2*DATA_WIDTH-1:0]      w_wide;
    logic [DATA_WIDTH-1:0]        w_half;
    logic [DATA_WIDTH-1:0]        w_rec;
    logic [PACKET_LEN-1:0]        w_asm_next;

    assign in_ready   = !r_asm_full;
    assign out_valid  = r_out_valid;
    assign y_rec      = r_y_rec;

    assign w_accept   = in_valid && !r_asm_full;
    assign w_last     = w_accept && (r_lane_cnt == LAST_LANE);
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // Lane 0 uses the live shift input since s_pkt only latches on that same edge.
    assign w_shift = (r_lane_cnt == '0) ? bit_shift : r_s_pkt;
    assign w_wide  = {{DATA_WIDTH{1'b0}}, in_data} << w_shift;
    assign w_half  = (w_shift == '0) ? '0 : (LANE_ONE << (w_shift - SHIFT_ONE));
    // Any bit shifted past the lane width means the value cannot be represented.
    assign w_rec   = (|w_wide[2*DATA_WIDTH-1:DATA_WIDTH]) ? '1
                                                          : (w_wide[DATA_WIDTH-1:0] | w_half);

    genvar gi;
    generate
        for (gi = 0; gi < REG_BANK_DEPTH; gi++) begin : g_lane
            assign w_asm_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                (w_accept && (r_lane_cnt == CW'(gi))) ? w_rec
                                                      : r_asm[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_asm <= w_asm_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane_cnt  <= '0;
            r_asm_full  <= 1'b0;
            r_s_pkt     <= '0;
            r_out_valid <= 1'b0;
            r_y_rec     <= '0;
        end else begin
            if (w_accept) begin
                r_lane_cnt <= w_last ? '0 : r_lane_cnt + CW'(1);
                if (r_lane_cnt == '0) begin
                    r_s_pkt <= bit_shift;
                end
            end

            if (w_last && w_out_free) begin
                r_y_rec     <= w_asm_next;
                r_out_valid <= 1'b1;
            end else if (w_last) begin
                r_asm_full  <= 1'b1;
            end else if (r_asm_full && w_out_hs) begin
                r_y_rec     <= r_asm;
                r_asm_full  <= 1'b0;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cs_dequantization.sv
// Bench for cs_dequantization: directed test-plan packets plus randomized traffic,
// compared every cycle against a packet-queue reference model.
module tb_cs_dequantization;
    localparam int DW = 16;
    localparam int N  = 16;
    localparam int SW = 4;
    localparam int PL = DW * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] bit_shift = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PL-1:0] y_rec;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    cs_dequantization #(
        .DATA_WIDTH(DW), .REG_BANK_DEPTH(N), .BIT_SHIFT_WIDTH(SW), .PACKET_LEN(PL)
    ) dut (
        .clk(clk), .rst(rst), .bit_shift(bit_shift), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .y_rec(y_rec),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rec(input logic [DW-1:0] q, input int s);
        int unsigned qq;
        qq = q;
        if (s == 0) return q;
        if (qq >= (32'd1 << (DW - s))) return '1;
        return DW'(qq * (32'd1 << s) + (32'd1 << (s - 1)));
    endfunction

    // Reference model: packets completed but not yet taken downstream.
    logic [PL-1:0] exp_q[$];
    logic [PL-1:0] m_pkt;
    logic [PL-1:0] last_y;
    int            m_idx;
    int            m_s;
    bit            m_acc, m_hs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_idx  = 0;
            m_s    = 0;
            last_y = '0;
        end else begin
            m_acc = in_valid && (exp_q.size() < 2);
            m_hs  = out_ready && (exp_q.size() > 0);
            if (m_hs) last_y = exp_q.pop_front();
            if (m_acc) begin
                if (m_idx == 0) m_s = bit_shift;
                m_pkt[m_idx*DW +: DW] = rec(in_data, m_s);
                if (m_idx == N - 1) begin
                    exp_q.push_back(m_pkt);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", PL'(in_ready), PL'(exp_q.size() < 2));
            chk("out_valid", PL'(out_valid), PL'(exp_q.size() > 0));
            chk("y_rec", y_rec, (exp_q.size() > 0) ? exp_q[0] : last_y);
        end
    end

    task automatic send_lane(input logic [DW-1:0] q, input logic [SW-1:0] s);
        bit done = 0;
        bit rdy;
        int t = 0;
        while (!done) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = q;
            bit_shift = s;
            rdy = in_ready;
            @(posedge clk);
            done = rdy;
            t++;
            if (!done && t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL lane_accept_timeout: got no accept expected accept within 200 cycles");
                done = 1;
            end
        end
    endtask

    task automatic stop_input();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        // Pin the model's reconstruction rule to hand-computed values.
        chk("model_s3_q0", PL'(rec(16'd0, 3)), PL'(16'd4));
        chk("model_s3_q5", PL'(rec(16'd5, 3)), PL'(16'd44));
        chk("model_s4_fff", PL'(rec(16'h0FFF, 4)), PL'(16'hFFF8));
        chk("model_s4_sat", PL'(rec(16'h1000, 4)), PL'(16'hFFFF));
        chk("model_s0_id", PL'(rec(16'h1234, 0)), PL'(16'h1234));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", PL'(in_ready), PL'(1'b1));
        chk("reset_out_valid", PL'(out_valid), PL'(1'b0));
        chk("reset_y_rec", y_rec, '0);

        // Basic reconstruction, shift 3, q_i = i.
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send_lane(16'(i), 4'd3);
        stop_input();
        chk("basic_valid", PL'(out_valid), PL'(1'b1));
        chk("basic_lane0", PL'(y_rec[0*DW +: DW]), PL'(16'd4));
        chk("basic_lane1", PL'(y_rec[1*DW +: DW]), PL'(16'd12));
        chk("basic_lane5", PL'(y_rec[5*DW +: DW]), PL'(16'd44));
        chk("basic_lane15", PL'(y_rec[15*DW +: DW]), PL'(16'd124));
        idle(1);
        chk("basic_valid_one_cycle", PL'(out_valid), PL'(1'b0));

        // Identity packet.
        for (int i = 0; i < N; i++) send_lane(16'h1234, 4'd0);
        stop_input();
        chk("ident_lane0", PL'(y_rec[0*DW +: DW]), PL'(16'h1234));
        chk("ident_lane15", PL'(y_rec[15*DW +: DW]), PL'(16'h1234));

        // Saturation packet.
        send_lane(16'h0FFF, 4'd4);
        send_lane(16'h1000, 4'd4);
        for (int i = 2; i < N; i++) send_lane(16'h0000, 4'd4);
        stop_input();
        chk("sat_lane0", PL'(y_rec[0*DW +: DW]), PL'(16'hFFF8));
        chk("sat_lane1", PL'(y_rec[1*DW +: DW]), PL'(16'hFFFF));
        chk("sat_lane2", PL'(y_rec[2*DW +: DW]), PL'(16'h0008));

        // Shift latched at lane 0 only.
        for (int i = 0; i < N; i++) send_lane(16'd1, (i < 8) ? 4'd2 : 4'd7);
        stop_input();
        chk("latch_lane8", PL'(y_rec[8*DW +: DW]), PL'(16'd6));
        chk("latch_lane15", PL'(y_rec[15*DW +: DW]), PL'(16'd6));
        idle(2);

        // Backpressure: A (shift 1, q=i) held, B (shift 2, q=i+1) parked.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send_lane(16'(i), 4'd1);
        for (int i = 0; i < N; i++) send_lane(16'(i + 1), 4'd2);
        stop_input();
        chk("bp_in_ready_low", PL'(in_ready), PL'(1'b0));
        chk("bp_hold_A", PL'(y_rec[3*DW +: DW]), PL'(16'd7));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_valid_kept", PL'(out_valid), PL'(1'b1));
        chk("bp_B_lane0", PL'(y_rec[0*DW +: DW]), PL'(16'd6));
        chk("bp_in_ready_back", PL'(in_ready), PL'(1'b1));
        idle(3);
        out_ready = 1'b1;
        idle(3);

        // Reset in the middle of a packet.
        for (int i = 0; i < 7; i++) send_lane(16'd9, 4'd3);
        stop_input();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", PL'(out_valid), PL'(1'b0));
        chk("mid_rst_y_rec", y_rec, '0);
        chk("mid_rst_in_ready", PL'(in_ready), PL'(1'b1));
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < N; i++) send_lane(16'd1, 4'd3);
        stop_input();
        chk("post_rst_valid", PL'(out_valid), PL'(1'b1));
        chk("post_rst_lane0", PL'(y_rec[0*DW +: DW]), PL'(16'd12));
        chk("post_rst_lane6", PL'(y_rec[6*DW +: DW]), PL'(16'd12));
        idle(2);

        // Randomized traffic with phases of heavy and light backpressure.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom % 4) != 0;
            in_data   = (($urandom % 3) == 0) ? 16'($urandom) : 16'($urandom % 64);
            bit_shift = 4'($urandom);
            if ((c / 500) % 2 == 0) out_ready = ($urandom % 4) != 0;
            else                    out_ready = ($urandom % 5) == 0;
        end
        out_ready = 1'b1;
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
